// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction fetch sequencer. Drives a synchronous
//                instruction memory one word per cycle, buffers the returned
//                words in a DEPTH-entry FIFO, handles redirects (flush) and
//                halts once the PC leaves the valid memory range.
//                Optional performance counters are enabled by defining the
//                macro FETCH_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int MEM_BITS = 11,
    parameter int DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        issue_ready,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        fetch_halted,
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_stall_cycles
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    // One extra bit so count + inflight never overflows the comparison
    localparam int c_OCC_W = c_CNT_W + 1;
    localparam logic [c_OCC_W-1:0] c_DEPTH = c_OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t               r_state;
    logic [31:0]          r_pc;
    logic [31:0]          r_req_pc;
    logic                 r_inflight;
    logic                 r_kill;
    logic                 r_halted;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [31:0]          r_buf_inst [DEPTH];
    logic [31:0]          r_buf_pc   [DEPTH];

    logic                 w_pc_in_range;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_issue;
    logic [c_OCC_W-1:0]   w_occ;

    // PC lies inside the instruction memory when no bit above MEM_BITS is set
    assign w_pc_in_range = ((r_pc >> MEM_BITS) == 32'd0);

    // Redirect overrides every buffer and fetch action in the same cycle
    assign w_pop  = (r_count != '0) && issue_ready && !redirect_valid;
    assign w_push = r_inflight && !r_kill && !redirect_valid;

    // Occupancy seen by the issue decision: a same-cycle pop frees a slot
    assign w_occ   = {1'b0, r_count} + c_OCC_W'(r_inflight) - c_OCC_W'(w_pop);
    assign w_issue = (r_state == ST_RUN) && w_pc_in_range &&
                     (w_occ < c_DEPTH) && !redirect_valid;

    assign imem_addr    = r_pc;
    assign out_valid    = (r_count != '0);
    assign out_inst     = r_buf_inst[r_head];
    assign out_pc       = r_buf_pc[r_head];
    assign fetch_halted = r_halted;

    // Control FSM: PC, in-flight tracking, FIFO pointers/count and state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= 32'd0;
            r_req_pc   <= 32'd0;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
            r_halted   <= 1'b0;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else if (redirect_valid) begin
            r_state    <= ST_FLUSH;
            r_pc       <= redirect_pc;
            r_kill     <= r_inflight;
            r_inflight <= 1'b0;
            r_halted   <= 1'b0;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            if (w_issue) begin
                r_pc     <= r_pc + 32'd1;
                r_req_pc <= r_pc;
            end
            r_inflight <= w_issue;
            if (w_push) r_tail <= r_tail + c_PTR_W'(1);
            if (w_pop)  r_head <= r_head + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            case (r_state)
                ST_RUN: begin
                    if (!w_pc_in_range && !r_inflight && (r_count == '0)) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // The killed return (if any) has been dropped by now
                    r_state <= ST_RUN;
                    r_kill  <= 1'b0;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // FIFO storage holds {instruction, pc}; contents only matter while counted
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_inst[r_tail] <= imem_rdata;
            r_buf_pc[r_tail]   <= r_req_pc;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic        w_stall;

    // Back-pressure stall: running, PC valid, but the buffer has no room
    assign w_stall = (r_state == ST_RUN) && w_pc_in_range && !w_issue &&
                     !redirect_valid;

    // Free-running performance counters, wrapping at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetch <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if (w_push)  r_perf_fetch <= r_perf_fetch + 32'd1;
            if (w_stall) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetch_count  = r_perf_fetch;
    assign perf_stall_cycles = r_perf_stall;
`else
    assign perf_fetch_count  = 32'd0;
    assign perf_stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer. A cycle table drives
//                the default-size instance through streaming, back-pressure,
//                redirects, halt and reset; a scoreboard queue checks every
//                popped entry. A hand-written sequence runs a MEM_BITS=4
//                instance to halt and resumes it with a redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        rst_a, redir_a, ready_a;
    logic [31:0] rpc_a, addr_a, rdata_a, inst_a, pc_a, pfc_a, pst_a;
    logic        valid_a, halt_a;

    // Instance B: MEM_BITS = 4
    logic        rst_b, redir_b, ready_b;
    logic [31:0] rpc_b, addr_b, rdata_b, inst_b, pc_b, pfc_b, pst_b;
    logic        valid_b, halt_b;

    fetch_sequencer u_dut_a (
        .clk               (clk),
        .rst               (rst_a),
        .redirect_valid    (redir_a),
        .redirect_pc       (rpc_a),
        .issue_ready       (ready_a),
        .imem_addr         (addr_a),
        .imem_rdata        (rdata_a),
        .out_valid         (valid_a),
        .out_inst          (inst_a),
        .out_pc            (pc_a),
        .fetch_halted      (halt_a),
        .perf_fetch_count  (pfc_a),
        .perf_stall_cycles (pst_a)
    );

    fetch_sequencer #(.MEM_BITS(4), .DEPTH(4)) u_dut_b (
        .clk               (clk),
        .rst               (rst_b),
        .redirect_valid    (redir_b),
        .redirect_pc       (rpc_b),
        .issue_ready       (ready_b),
        .imem_addr         (addr_b),
        .imem_rdata        (rdata_b),
        .out_valid         (valid_b),
        .out_inst          (inst_b),
        .out_pc            (pc_b),
        .fetch_halted      (halt_b),
        .perf_fetch_count  (pfc_b),
        .perf_stall_cycles (pst_b)
    );

    // Synchronous memories: word n holds n + 0x100
    always @(posedge clk) begin
        rdata_a <= addr_a + 32'h100;
        rdata_b <= addr_b + 32'h100;
    end

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ea;
        logic        eh;
        logic        cp;
        logic [31:0] efc;
        logic [31:0] est;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic d, input logic [31:0] rpc,
                       input logic y, input logic ev, input logic [31:0] epc,
                       input logic [31:0] ea, input logic eh);
        vec_t v;
        v.rst = r;  v.redir = d; v.rpc = rpc; v.rdy = y;
        v.ev  = ev; v.epc = epc; v.ea = ea;   v.eh = eh;
        v.cp  = 1'b0; v.efc = 32'd0; v.est = 32'd0;
        tbl.push_back(v);
    endtask

    task automatic add_perf(input logic [31:0] fc, input logic [31:0] st);
        int k;
        k = tbl.size() - 1;
        tbl[k].cp = 1'b1;
`ifdef FETCH_PERF_EN
        tbl[k].efc = fc;
        tbl[k].est = st;
`else
        tbl[k].efc = 32'd0;
        tbl[k].est = 32'd0;
`endif
    endtask

    task automatic reload(input logic [31:0] start);
        sb_q.delete();
        for (int k = 0; k < 16; k++) sb_q.push_back(start + 32'(k));
    endtask

    initial begin
        vec_t        v;
        logic [31:0] exp_pc, got_pc;
        logic        seen;
        int          exp_b;

        rst_a = 1'b1; redir_a = 1'b0; rpc_a = 32'd0; ready_a = 1'b1;
        rst_b = 1'b1; redir_b = 1'b0; rpc_b = 32'd0; ready_b = 1'b1;

        // ---- cycle table for instance A --------------------------------
        add(1,0,0,1, 0,0,0,0); add_perf(0, 0);
        // streaming from reset, one entry per cycle from cycle 2
        add(0,0,0,1, 0,0,0,0);
        add(0,0,0,1, 0,0,1,0);
        for (int n = 0; n < 4; n++) add(0,0,0,1, 1,32'(n),32'(n+2),0);
        // back-pressure: ready low for 10 cycles
        add(1,0,0,0, 0,0,0,0); add_perf(0, 0);
        add(0,0,0,0, 0,0,0,0);
        add(0,0,0,0, 0,0,1,0);
        add(0,0,0,0, 1,0,2,0);
        add(0,0,0,0, 1,0,3,0);
        for (int n = 0; n < 6; n++) add(0,0,0,0, 1,0,4,0);
        add(0,0,0,1, 1,0,4,0); add_perf(4, 6);
        for (int n = 1; n < 5; n++) add(0,0,0,1, 1,32'(n),32'(n+4),0);
        // redirect with 3 buffered + 1 in flight, simultaneous pop
        add(0,1,32'h40,1, 1,5,9,0);
        add(0,0,0,1, 0,0,32'h40,0);
        add(0,0,0,1, 0,0,32'h40,0);
        add(0,0,0,1, 0,0,32'h41,0);
        add(0,0,0,1, 1,32'h40,32'h42,0);
        add(0,0,0,1, 1,32'h41,32'h43,0);
        // redirect near top of memory, drain to halt
        add(0,1,32'h7FE,1, 1,32'h42,32'h44,0);
        add(0,0,0,1, 0,0,32'h7FE,0);
        add(0,0,0,1, 0,0,32'h7FE,0);
        add(0,0,0,1, 0,0,32'h7FF,0);
        add(0,0,0,1, 1,32'h7FE,32'h800,0);
        add(0,0,0,1, 1,32'h7FF,32'h800,0);
        add(0,0,0,1, 0,0,32'h800,0);
        add(0,0,0,1, 0,0,32'h800,1);
        // out-of-range redirect from HALT goes straight back to HALT
        add(0,1,32'h800,1, 0,0,32'h800,1);
        add(0,0,0,1, 0,0,32'h800,0);
        add(0,0,0,1, 0,0,32'h800,0);
        add(0,0,0,1, 0,0,32'h800,1);
        // in-range redirect resumes fetching
        add(0,1,5,1, 0,0,32'h800,1);
        add(0,0,0,1, 0,0,5,0);
        add(0,0,0,1, 0,0,5,0);
        add(0,0,0,1, 0,0,6,0);
        add(0,0,0,1, 1,5,7,0);
        // reset while buffer occupied and a fetch in flight
        add(1,0,0,0, 0,0,0,0);
        add(0,0,0,0, 0,0,0,0);
        add(0,0,0,0, 0,0,1,0);
        add(0,0,0,0, 1,0,2,0);
        add(0,0,0,0, 1,0,3,0);
        add(0,0,0,0, 1,0,4,0);
        add(1,0,0,1, 0,0,0,0); add_perf(0, 0);
        add(0,0,0,1, 0,0,0,0);
        add(0,0,0,1, 0,0,1,0);
        add(0,0,0,1, 1,0,2,0);
        add(0,0,0,1, 1,1,3,0);
        add(0,0,0,1, 1,2,4,0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            rst_a = v.rst; redir_a = v.redir; rpc_a = v.rpc; ready_a = v.rdy;
            #1;
            check($sformatf("r%0d_addr", i),  addr_a,        v.ea);
            check($sformatf("r%0d_valid", i), 32'(valid_a),  32'(v.ev));
            check($sformatf("r%0d_halted", i), 32'(halt_a),  32'(v.eh));
            if (v.ev) check($sformatf("r%0d_pc", i), pc_a, v.epc);
            if (v.cp) begin
                check($sformatf("r%0d_perf_fetch", i), pfc_a, v.efc);
                check($sformatf("r%0d_perf_stall", i), pst_a, v.est);
            end
            // scoreboard: every expected pop consumes the next expected pc
            if (v.ev && v.rdy && !v.rst && !v.redir) begin
                if (sb_q.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL r%0d_sb_empty: pop with no expected entry", i);
                end else begin
                    exp_pc = sb_q.pop_front();
                    check($sformatf("r%0d_sb_pc", i),   pc_a,   exp_pc);
                    check($sformatf("r%0d_sb_inst", i), inst_a, exp_pc + 32'h100);
                end
            end
            if (v.rst)        reload(32'd0);
            else if (v.redir) reload(v.rpc);
            @(posedge clk);
            @(negedge clk);
        end

        // ---- instance B: MEM_BITS=4, run to halt ----------------------
        rst_b = 1'b0; ready_b = 1'b1;
        seen  = 1'b0;
        exp_b = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            #1;
            if (valid_b) begin
                check($sformatf("b_pc%0d", exp_b),   pc_b,   32'(exp_b));
                check($sformatf("b_inst%0d", exp_b), inst_b, 32'(exp_b) + 32'h100);
                exp_b++;
            end
            if (halt_b) seen = 1'b1;
            else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        check("b_halt_reached", 32'(seen), 32'd1);
        check("b_entries_before_halt", 32'(exp_b), 32'd16);
        check("b_addr_at_halt", addr_b, 32'd16);

        // redirect out of HALT to word 2
        redir_b = 1'b1; rpc_b = 32'd2;
        @(posedge clk);
        @(negedge clk);
        redir_b = 1'b0;
        #1;
        check("b_halt_clear", 32'(halt_b), 32'd0);
        check("b_flush_valid", 32'(valid_b), 32'd0);
        seen = 1'b0;
        got_pc = 32'hFFFF_FFFF;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (valid_b) begin
                seen   = 1'b1;
                got_pc = pc_b;
                check("b_resume_inst", inst_b, 32'h102);
            end else begin
                @(posedge clk);
                @(negedge clk);
                #1;
            end
        end
        check("b_resume_seen", 32'(seen), 32'd1);
        check("b_resume_pc", got_pc, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter MEM_BITS, default 11: instruction memory word-address width; valid PCs are 0 .. 2^MEM_BITS-1.
REQ-002 SHALL have parameter DEPTH, default 4: fetch buffer entries; power of two, >= 2.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 redirect_valid  in  1  branch/jump resolution; load new PC and flush.
REQ-006 redirect_pc  in  32  word-address target for redirect.
REQ-007 issue_ready  in  1  downstream consumer accepts the head entry this cycle.
REQ-008 imem_addr  out  32  word address to the synchronous instruction memory; equals the PC register.
REQ-009 imem_rdata  in  32  memory data; valid on the cycle after the address was presented.
REQ-010 out_valid  out  1  head buffer entry is valid.
REQ-011 out_inst  out  32  head instruction word.
REQ-012 out_pc  out  32  word address of the head instruction.
REQ-013 fetch_halted  out  1  high while the sequencer is in state HALT.
REQ-014 perf_fetch_count  out  32  instructions written into the buffer (see Configuration).
REQ-015 perf_stall_cycles  out  32  RUN cycles with no fetch issued because of back-pressure.

Function
REQ-016 States SHALL be RUN, FLUSH and HALT, encoded in a 2-bit register.
REQ-017 In RUN, a fetch SHALL issue when (count + inflight + pop-adjust) < DEPTH and PC <= 2^MEM_BITS-1; pop-adjust = -1 when the head is popped in the same cycle; on issue, PC <= PC+1 and inflight <= 1.
REQ-018 The entry with inflight=1 and no kill SHALL write {imem_rdata, PC_of_request} to the tail on the next rising edge; fetch-to-out_valid latency = 2 cycles when the buffer is empty.
REQ-019 A pop SHALL occur when out_valid && issue_ready; head advances modulo DEPTH.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; a push into a full buffer SHALL never occur (guaranteed by REQ-017).
REQ-021 Pointers SHALL wrap at DEPTH; count is $clog2(DEPTH)+1 bits.
REQ-022 A redirect in any state SHALL, on the same edge, clear count/pointers, set PC <= redirect_pc, mark any in-flight return as killed, and enter FLUSH; out_valid is low on the next cycle.
REQ-023 Redirect SHALL take priority over a simultaneous pop, push or fetch issue.
REQ-024 FLUSH SHALL last exactly one cycle, issue no fetch, drop the killed return, and go to RUN.
REQ-025 RUN SHALL go to HALT when PC > 2^MEM_BITS-1, inflight = 0 and count = 0; buffered entries drain normally first.
REQ-026 HALT SHALL issue no fetches and is left only by redirect (to FLUSH).
REQ-027 A redirect_pc outside the valid range SHALL be accepted; the sequencer then drains to HALT without fetching.

Reset
REQ-028 While rst is high: PC=0, state=RUN, count=0, pointers=0, inflight=0, kill=0, out_valid=0, fetch_halted=0, perf counters=0.
REQ-029 Reset mid-operation SHALL discard buffer contents and any in-flight return; the first fetch (address 0) issues on the first rising edge after rst falls.
REQ-030 Buffer data storage SHALL not require reset; out_inst/out_pc are don't-care while out_valid=0.

Configuration
REQ-031 Macro FETCH_PERF_EN defined: perf_fetch_count increments on every non-killed push; perf_stall_cycles increments each RUN cycle in which PC is in range but no fetch issues; both wrap at 2^32.
REQ-032 FETCH_PERF_EN undefined: both perf ports are tied to 0 and no counter flops exist.

Verification
REQ-033 Reset release, issue_ready=1, memory word n = n+0x100 -> out_pc 0,1,2,... one per cycle from cycle 2, out_inst matching.
REQ-034 issue_ready=0 for 10 cycles -> exactly DEPTH(4) entries buffered, imem_addr stops at 4, perf_stall_cycles += 6 with FETCH_PERF_EN.
REQ-035 Redirect to 0x40 while buffer holds 3 entries and a fetch is in flight -> next cycle out_valid=0; first out_pc is 0x40; no stale entry appears.
REQ-036 Redirect asserted in same cycle as a pop -> pop ignored, FLUSH entered, following outputs start at redirect_pc.
REQ-037 MEM_BITS=4, run from 0 -> last out_pc 15, then fetch_halted=1; redirect to 2 -> fetch_halted=0 after one cycle, out_pc 2 resumes.
REQ-038 rst pulsed while buffer full and fetch in flight -> all outputs at reset values; refetch from PC 0 with no leftover entries.
